// File: rtl/heading_pid.sv
// Pipelined P+I+D heading controller producing saturated left/right wheel speeds.
// Optional derivative path enabled by defining HEADING_PID_DTERM_EN.
module heading_pid #(
    parameter logic [3:0] P_COEF = 4'd3,
    parameter logic [4:0] D_COEF = 5'd14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] error,
    input  logic        err_vld,
    input  logic        moving,
    input  logic [9:0]  frwrd,
    output logic [10:0] lft_spd,
    output logic [10:0] rght_spd
);

    logic signed [9:0]  err_sat;
    logic signed [9:0]  err_q;
    logic signed [14:0] integ;
    logic signed [14:0] integ_sum;
    logic               integ_ovf;
    logic signed [13:0] p_term;
    logic signed [13:0] i_term;
    logic signed [13:0] d_term;
    logic signed [13:0] pid;
    logic signed [11:0] corr;
    logic signed [11:0] frwrd_ext;
    logic signed [11:0] lft_sum;
    logic signed [11:0] rght_sum;
    logic        [10:0] lft_sat;
    logic        [10:0] rght_sat;
    logic               unused_pid_lsbs;

    always_comb begin
        if (error[11:9] == 3'b000 || error[11:9] == 3'b111)
            err_sat = error[9:0];
        else if (error[11])
            err_sat = 10'h200;
        else
            err_sat = 10'h1FF;
    end

    // Overflow freezes the integrator rather than clamping it to the rail.
    assign integ_sum = integ + $signed({{5{err_sat[9]}}, err_sat});
    assign integ_ovf = (integ[14] == err_sat[9]) && (integ_sum[14] != integ[14]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            integ <= '0;
        end else begin
            if (err_vld)
                err_q <= err_sat;
            if (!moving)
                integ <= '0;
            else if (err_vld && !integ_ovf)
                integ <= integ_sum;
        end
    end

`ifdef HEADING_PID_DTERM_EN
    logic signed [9:0]  prev_err;
    logic signed [7:0]  d_q;
    logic signed [10:0] d_diff;
    logic signed [7:0]  d_sat;

    assign d_diff = $signed({err_sat[9], err_sat}) - $signed({prev_err[9], prev_err});

    always_comb begin
        if (d_diff[10:7] == 4'b0000 || d_diff[10:7] == 4'b1111)
            d_sat = d_diff[7:0];
        else if (d_diff[10])
            d_sat = 8'h80;
        else
            d_sat = 8'h7F;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_err <= '0;
            d_q      <= '0;
        end else begin
            if (err_vld)
                d_q <= d_sat;
            if (!moving)
                prev_err <= '0;
            else if (err_vld)
                prev_err <= err_sat;
        end
    end

    assign d_term = $signed({{6{d_q[7]}}, d_q}) * $signed({9'd0, D_COEF});
`else
    assign d_term = '0;
`endif

    assign p_term = $signed({{4{err_q[9]}}, err_q}) * $signed({10'd0, P_COEF});
    assign i_term = $signed({{5{integ[14]}}, integ[14:6]});
    assign pid    = p_term + i_term + d_term;

    // Floor divide by 8; the 11-bit quotient is sign-extended into the 12-bit mix.
    assign corr            = $signed({pid[13], pid[13:3]});
    assign unused_pid_lsbs = ^pid[2:0];

    assign frwrd_ext = $signed({2'b00, frwrd});
    assign lft_sum   = frwrd_ext + corr;
    assign rght_sum  = frwrd_ext - corr;

    always_comb begin
        if (lft_sum[11] == lft_sum[10])
            lft_sat = lft_sum[10:0];
        else if (lft_sum[11])
            lft_sat = 11'h400;
        else
            lft_sat = 11'h3FF;

        if (rght_sum[11] == rght_sum[10])
            rght_sat = rght_sum[10:0];
        else if (rght_sum[11])
            rght_sat = 11'h400;
        else
            rght_sat = 11'h3FF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
        end else if (!moving) begin
            lft_spd  <= '0;
            rght_spd <= '0;
        end else begin
            lft_spd  <= lft_sat;
            rght_spd <= rght_sat;
        end
    end

endmodule

// File: tb/tb_heading_pid.sv
// Scoreboard bench for heading_pid: a behavioural model queues expected wheel
// speeds per cycle, popped and compared after each edge; spec scenarios add fixed checks.
module tb_heading_pid;

    logic        clk;
    logic        rst_n;
    logic [11:0] error;
    logic        err_vld;
    logic        moving;
    logic [9:0]  frwrd;
    logic [10:0] lft_spd;
    logic [10:0] rght_spd;

    heading_pid #(.P_COEF(4'd3), .D_COEF(5'd14)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .error    (error),
        .err_vld  (err_vld),
        .moving   (moving),
        .frwrd    (frwrd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd)
    );

`ifdef HEADING_PID_DTERM_EN
    localparam bit DT      = 1'b1;
    localparam int S1_LFT  = 468;
    localparam int S1_RGHT = 44;
    localparam int SAT_RGHT = 609;
`else
    localparam bit DT      = 1'b0;
    localparam int S1_LFT  = 293;
    localparam int S1_RGHT = 219;
    localparam int SAT_RGHT = 831;
`endif

    typedef struct {
        int lft;
        int rght;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int m_errq, m_dq, m_prev, m_integ;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_reset();
        m_errq  = 0;
        m_dq    = 0;
        m_prev  = 0;
        m_integ = 0;
    endfunction

    // Drive one cycle of stimulus, queue the model's output for this edge, then compare.
    task automatic step(input bit v, input int e, input bit mv, input int fw);
        exp_t x;
        exp_t got;
        int p, i, d, pid, corr, es, s;
        err_vld = v;
        error   = e[11:0];
        moving  = mv;
        frwrd   = fw[9:0];

        p    = m_errq * 3;
        i    = m_integ >>> 6;
        d    = DT ? m_dq * 14 : 0;
        pid  = p + i + d;
        corr = pid >>> 3;
        x.lft  = mv ? sat(fw + corr, -1024, 1023) : 0;
        x.rght = mv ? sat(fw - corr, -1024, 1023) : 0;
        sbq.push_back(x);

        es = sat(e, -512, 511);
        if (v) begin
            m_errq = es;
            m_dq   = sat(es - m_prev, -128, 127);
            m_prev = es;
            if (mv) begin
                s = m_integ + es;
                if (s >= -16384 && s <= 16383) m_integ = s;
            end
        end
        if (!mv) begin
            m_integ = 0;
            m_prev  = 0;
        end

        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            got = sbq.pop_front();
            check("sb_lft", int'($signed(lft_spd)), got.lft);
            check("sb_rght", int'($signed(rght_spd)), got.rght);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n   = 1'b0;
        error   = '0;
        err_vld = 1'b0;
        moving  = 1'b0;
        frwrd   = '0;
        model_reset();
        #2;
        check("rst_lft", int'($signed(lft_spd)), 0);
        check("rst_rght", int'($signed(rght_spd)), 0);
        check("rst_integ", int'(dut.integ), 0);
        #10;
        rst_n = 1'b1;

        // First sample
        step(1'b1, 100, 1'b1, 256);
        step(1'b0, 100, 1'b1, 256);
        check("s1_lft", int'($signed(lft_spd)), S1_LFT);
        check("s1_rght", int'($signed(rght_spd)), S1_RGHT);

        // frwrd change without a strobe
        step(1'b0, 0, 1'b1, 300);
        check("fw_lft", int'($signed(lft_spd)), S1_LFT + 44);

        // Saturation from reset
        reset_dut();
        step(1'b1, 2000, 1'b1, 1023);
        step(1'b0, 2000, 1'b1, 1023);
        check("sat_lft", int'($signed(lft_spd)), 1023);
        check("sat_rght", int'($signed(rght_spd)), SAT_RGHT);

        // Integrator overflow freeze
        reset_dut();
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, -512, 1'b1, 500);
            if (k == 32) check("integ_at32", int'(dut.integ), -16384);
        end
        check("integ_hold", int'(dut.integ), -16384);
        step(1'b1, 100, 1'b1, 500);
        check("integ_recover", int'(dut.integ), -16284);
        step(1'b0, 0, 1'b1, 500);

        // moving drop with a simultaneous strobe: clear wins
        step(1'b1, 50, 1'b0, 500);
        check("drop_lft", int'($signed(lft_spd)), 0);
        check("drop_rght", int'($signed(rght_spd)), 0);
        check("drop_integ", int'(dut.integ), 0);
`ifdef HEADING_PID_DTERM_EN
        check("drop_prev", int'(dut.prev_err), 0);
`endif
        step(1'b1, 0, 1'b1, 200);
        step(1'b0, 0, 1'b1, 200);
        check("rerise_lft", int'($signed(lft_spd)), 200);
        check("rerise_rght", int'($signed(rght_spd)), 200);

        // Asynchronous reset between edges
        step(1'b1, 300, 1'b1, 400);
        step(1'b1, -200, 1'b1, 400);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_lft", int'($signed(lft_spd)), 0);
        check("arst_rght", int'($signed(rght_spd)), 0);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 100, 1'b1, 256);
        step(1'b0, 100, 1'b1, 256);
        check("arst_s1_lft", int'($signed(lft_spd)), S1_LFT);
        check("arst_s1_rght", int'($signed(rght_spd)), S1_RGHT);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 4095)) - 2048,
                 $urandom_range(0, 9) != 0, int'($urandom_range(0, 1023)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/heading_pid.md
# heading_pid

- Closed-loop heading controller that sits directly upstream of the motor driver stage.
- Takes the signed heading error from the heading-estimation logic and the commanded forward speed, and produces the signed 11-bit left/right wheel speed commands consumed by the motor driver.
- Implements a pipelined P + I + D calculation, with a saturating integrator and a saturating final mix.

## Interface
- P_COEF, 4'd3 — unsigned proportional gain.
- D_COEF, 5'd14 — unsigned derivative gain.
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- error  input  12  signed heading error.
- err_vld  input  1  one-cycle strobe; `error` is valid this cycle.
- moving  input  1  high while the robot is commanded to move.
- frwrd  input  10  unsigned forward speed.
- lft_spd  output  11  signed left wheel speed command.
- rght_spd  output  11  signed right wheel speed command.

## Operation
- **Error saturation (comb):** saturate `error` to 10-bit signed `err_sat` (-512..511).
- **Stage 1, on `err_vld`:**
  - Register `err_q <= err_sat`.
  - Compute `d_diff = err_sat - prev_err` at 11 bits, saturate to 8-bit signed (-128..127), register it as `d_q`.
  - Update `prev_err <= err_sat`.
  - Integrator update: `integ` is 15-bit signed; `integ <= integ + sext(err_sat)` when `err_vld & moving`.
- **Integrator overflow:**
  - If both addends have the same sign and the sum sign differs, `integ` holds its old value.
  - This freezes the integrator at its last value; it does not clamp to the rail.
- **Integrator clear:**
  - When `moving == 0`, `integ` clears to 0 every cycle.
  - `prev_err` clears to 0 every cycle under the same condition.
- **Hold:** without `err_vld`, the stage-1 registers hold.
- **Stage 2 (comb into output registers):**
  - `P = err_q * P_COEF` (14-bit signed).
  - `I = integ >>> 6`, sign-extended to 14 bits.
  - `D = d_q * D_COEF` (14-bit signed).
  - `PID = P + I + D` (14-bit; it cannot overflow with the default gains).
  - `corr = PID >>> 3` (arithmetic shift, i.e. floor).
- **Mix:**
  - `lft = {0,frwrd} + corr`, `rght = {0,frwrd} - corr`, computed at 12 bits.
  - Each result saturates to 11-bit signed (-1024..1023).
- **Output registers:** `lft_spd`/`rght_spd` update every cycle from the stage-2 result. They are forced to 0 when `moving == 0`.

## Timing
- **Reset values:** `lft_spd`, `rght_spd`, `err_q`, `d_q`, `prev_err` and `integ` are all 0.
- **Latency:** an `err_vld` accepted at edge N updates stage 1 at edge N; the outputs reflect it at edge N+1, one cycle later.
- **`frwrd` change:** a change with no `err_vld` appears at the outputs after one edge.
- **`moving` falling:** outputs are 0 at the next edge. `integ` and `prev_err` are 0 at that same edge, even if `err_vld` is high simultaneously; clear wins over accumulate.
- **Reset assertion:** reset mid-operation immediately zeroes all registers, asynchronously. The first `err_vld` after release behaves as if it were the first sample after power-up.
- **`err_vld`:** there is no back-pressure; it may be high on consecutive cycles, and each such cycle is a new sample.

## Configuration
- **`HEADING_PID_DTERM_EN` defined:** the derivative path (`prev_err`, `d_q`, `D`) is present as described above.
- **Undefined:**
  - `prev_err` and `d_q` are not implemented, and D is 0.
  - `PID = P + I`.
  - All other behaviour and latency are unchanged.

## Test plan
- **First sample:** reset, then `moving=1`, `frwrd=256`, a single `err_vld` with `error=100`.
  - DTERM_EN: P=300, I=1, D=1400, PID=1701, corr=212, so `lft_spd=468`, `rght_spd=44` one edge after the strobe.
  - Without DTERM_EN: corr=37, so `lft_spd=293`, `rght_spd=219`.
- **Saturation:** `error=2000`, `frwrd=1023`, `moving=1`, from reset.
  - `err_sat=511`, `d_q=127`, PID=3318, corr=414.
  - `lft_spd` saturates to 1023; `rght_spd=609`.
- **Integrator overflow:** 40 consecutive strobes of `error=-512` with `moving=1`.
  - `integ` reaches -16384 at strobe 32 and holds there; I=-256 thereafter.
  - A subsequent `error=+100` sample moves `integ` to -16284.
- **`moving` drop:** drop `moving` mid-run with `err_vld` high on the same cycle.
  - Next edge: `lft_spd=rght_spd=0`, `integ=0`, `prev_err=0`.
  - Re-raising `moving` with `error=0`, `frwrd=200` gives 200/200.
- **Asynchronous reset:** assert `rst_n` low between clock edges during activity.
  - Outputs are 0 immediately, without waiting for a clock edge.
  - After release, repeating scenario 1 reproduces 468/44.
